// File: rtl/ws2812b_pkg.sv
// Shared constants and the queue entry layout for the WS2812B pixel queue.
// Entry layout: colour in [32:9], repeat count in [8:1], latch flag in [0].
package ws2812b_pkg;

   localparam int unsigned PIXEL_W = 24;
   localparam int unsigned RPT_W   = 8;
   localparam int unsigned ENTRY_W = 33;

   localparam int unsigned ColourLsb = 9;
   localparam int unsigned RptLsb    = 1;
   localparam int unsigned LatchBit  = 0;

   typedef struct packed {
      logic [PIXEL_W-1:0] colour;
      logic [RPT_W-1:0]   rpt;
      logic               latch;
   } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter, synchronous active-high reset and clear.
// A push into a full FIFO is ignored even when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      level_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LvlFull);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !clr_i && !full_o;
   assign do_pop  = pop_i && !clr_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
         end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage has no reset so it can map onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ws2812b_pixel_queue.sv
// Assembles G,R,B byte writes into pixels, queues them with repeat/latch info and
// presents them to the WS2812B serializer over a valid/ready handshake.
module ws2812b_pixel_queue
   import ws2812b_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         byte_in,
   input  logic               byte_we,
   input  logic [RPT_W-1:0]   rpt_in,
   input  logic               latch_in,
   input  logic               flush,
   output logic [PIXEL_W-1:0] data_out,
   output logic               valid,
   output logic               latch,
   input  logic               ready,
   output logic [AW:0]        level,
   output logic               full,
   output logic               idle,
   output logic               overflow
);

   logic [1:0]         bcnt_q, bcnt_d;
   logic [7:0]         g_q, g_d;
   logic [7:0]         r_q, r_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;
   logic [PIXEL_W-1:0] data_q, data_d;
   logic               lflag_q, lflag_d;
   logic [RPT_W-1:0]   remain_q, remain_d;

   logic               xfer, push, pop;
   logic               fifo_full, fifo_empty;
   logic [AW:0]        fifo_level;
   entry_t             wr_entry, head;

   always_comb begin
      xfer     = valid_q && ready;
      push     = byte_we && (bcnt_q == 2'd2) && !flush;
      // Refill when the output register is empty or its last repetition is leaving.
      pop      = !flush && !fifo_empty && (!valid_q || (xfer && (remain_q == '0)));
      wr_entry = '{colour: {g_q, r_q, byte_in}, rpt: rpt_in, latch: latch_in};
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (flush),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      bcnt_d   = bcnt_q;
      g_d      = g_q;
      r_d      = r_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      data_d   = data_q;
      lflag_d  = lflag_q;
      remain_d = remain_q;
      if (flush) begin
         bcnt_d   = '0;
         ovf_d    = 1'b0;
         valid_d  = 1'b0;
         data_d   = '0;
         lflag_d  = 1'b0;
         remain_d = '0;
      end else begin
         if (byte_we) begin
            case (bcnt_q)
               2'd0: begin
                  g_d    = byte_in;
                  bcnt_d = 2'd1;
               end
               2'd1: begin
                  r_d    = byte_in;
                  bcnt_d = 2'd2;
               end
               default: bcnt_d = 2'd0;
            endcase
         end
         if (push && fifo_full) ovf_d = 1'b1;
         if (pop) begin
            valid_d  = 1'b1;
            data_d   = head.colour;
            remain_d = head.rpt;
            lflag_d  = head.latch;
         end else if (xfer) begin
            if (remain_q != '0) begin
               remain_d = remain_q - 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q   <= '0;
         g_q      <= '0;
         r_q      <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         lflag_q  <= 1'b0;
         remain_q <= '0;
      end else begin
         bcnt_q   <= bcnt_d;
         g_q      <= g_d;
         r_q      <= r_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         lflag_q  <= lflag_d;
         remain_q <= remain_d;
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
   assign latch    = lflag_q && (remain_q == '0);
   assign level    = fifo_level;
   assign full     = fifo_full;
   assign overflow = ovf_q;
   assign idle     = fifo_empty && (bcnt_q == 2'd0) && !valid_q;

endmodule

// File: tb/tb_ws2812b_pixel_queue.sv
// Directed self-checking bench for ws2812b_pixel_queue: assembly, repeat, latch,
// overflow, simultaneous push/pop, flush and reset behaviour.
module tb_ws2812b_pixel_queue;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_we;
   logic [7:0]  rpt_in;
   logic        latch_in;
   logic        flush;
   logic [23:0] data_out;
   logic        valid;
   logic        latch;
   logic        ready;
   logic [3:0]  level;
   logic        full;
   logic        idle;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ws2812b_pixel_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .byte_in  (byte_in),
      .byte_we  (byte_we),
      .rpt_in   (rpt_in),
      .latch_in (latch_in),
      .flush    (flush),
      .data_out (data_out),
      .valid    (valid),
      .latch    (latch),
      .ready    (ready),
      .level    (level),
      .full     (full),
      .idle     (idle),
      .overflow (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      byte_in = b;
      byte_we = 1'b1;
      tick();
      byte_we = 1'b0;
   endtask

   task automatic push_pixel(input logic [23:0] px, input logic [7:0] rpt, input logic lat);
      rpt_in   = rpt;
      latch_in = lat;
      write_byte(px[23:16]);
      write_byte(px[15:8]);
      write_byte(px[7:0]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({valid, latch, full, idle, overflow} !== 5'b00010) begin
         n_err++;
         $display("FAIL reset_flags: got %b want %b",
                  {valid, latch, full, idle, overflow}, 5'b00010);
      end
      n_cmp++;
      if (data_out !== 24'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h want %h", data_out, 24'h0);
      end
      n_cmp++;
      if (level !== 4'd0) begin
         n_err++;
         $display("FAIL reset_level: got %0d want 0", level);
      end
   endtask

   task automatic test_single();
      ready = 1'b1;
      push_pixel(24'h112233, 8'd0, 1'b1);
      n_cmp++;
      if (level !== 4'd1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_queued: got level=%0d valid=%b want level=1 valid=0", level, valid);
      end
      tick();
      n_cmp++;
      if (valid !== 1'b1 || data_out !== 24'h112233 || latch !== 1'b1) begin
         n_err++;
         $display("FAIL single_out: got v=%b d=%h l=%b want v=1 d=112233 l=1",
                  valid, data_out, latch);
      end
      n_cmp++;
      if (level !== 4'd0) begin
         n_err++;
         $display("FAIL single_level: got %0d want 0", level);
      end
      tick();
      n_cmp++;
      if (valid !== 1'b0 || idle !== 1'b1) begin
         n_err++;
         $display("FAIL single_done: got v=%b idle=%b want v=0 idle=1", valid, idle);
      end
      ready = 1'b0;
   endtask

   task automatic test_repeat();
      logic exp_l;
      ready = 1'b0;
      push_pixel(24'h00FF00, 8'd4, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         repeat (9) tick();
         exp_l = (k == 4);
         n_cmp++;
         if (valid !== 1'b1 || data_out !== 24'h00FF00) begin
            n_err++;
            $display("FAIL repeat_hold[%0d]: got v=%b d=%h want v=1 d=00ff00", k, valid, data_out);
         end
         n_cmp++;
         if (latch !== exp_l) begin
            n_err++;
            $display("FAIL repeat_latch[%0d]: got %b want %b", k, latch, exp_l);
         end
         ready = 1'b1;
         tick();
         ready = 1'b0;
      end
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL repeat_count: valid got %b want 0 after 5 transfers", valid);
      end
   endtask

   task automatic test_overflow();
      logic [23:0] px;
      ready = 1'b0;
      // Blocker pixel occupies the output register so eight more fill the queue.
      push_pixel(24'h0000A0, 8'd0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         px = 24'(i);
         push_pixel(px, 8'd0, 1'b0);
      end
      n_cmp++;
      if (full !== 1'b1 || overflow !== 1'b0 || level !== 4'd8) begin
         n_err++;
         $display("FAIL ovf_full: got full=%b ovf=%b level=%0d want 1 0 8", full, overflow, level);
      end
      push_pixel(24'h000009, 8'd0, 1'b0);
      n_cmp++;
      if (overflow !== 1'b1 || level !== 4'd8) begin
         n_err++;
         $display("FAIL ovf_flag: got ovf=%b level=%0d want 1 8", overflow, level);
      end
      ready = 1'b1;
      n_cmp++;
      if (valid !== 1'b1 || data_out !== 24'h0000A0) begin
         n_err++;
         $display("FAIL ovf_blocker: got v=%b d=%h want v=1 d=0000a0", valid, data_out);
      end
      for (int i = 1; i <= 8; i++) begin
         tick();
         px = 24'(i);
         n_cmp++;
         if (valid !== 1'b1 || data_out !== px) begin
            n_err++;
            $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, valid, data_out, px);
         end
      end
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_absent: got valid=%b d=%h want valid=0", valid, data_out);
      end
      ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [23:0] px;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready = 1'b0;
      for (int i = 0; i <= 3; i++) begin
         px = 24'h100000 + 24'(i);
         push_pixel(px, 8'd0, 1'b0);
      end
      n_cmp++;
      if (level !== 4'd3) begin
         n_err++;
         $display("FAIL simul_setup: level got %0d want 3", level);
      end
      rpt_in   = 8'd0;
      latch_in = 1'b0;
      write_byte(8'h10);
      write_byte(8'h00);
      ready = 1'b1;
      write_byte(8'h04);
      n_cmp++;
      if (level !== 4'd3 || data_out !== 24'h100001) begin
         n_err++;
         $display("FAIL simul_level3: got level=%0d d=%h want 3 100001", level, data_out);
      end
      for (int i = 2; i <= 4; i++) begin
         tick();
         px = 24'h100000 + 24'(i);
         n_cmp++;
         if (valid !== 1'b1 || data_out !== px) begin
            n_err++;
            $display("FAIL simul_order[%0d]: got v=%b d=%h want v=1 d=%h", i, valid, data_out, px);
         end
      end
      tick();
      ready = 1'b0;
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL simul_drain: valid got %b want 0", valid);
      end

      for (int i = 0; i <= 8; i++) begin
         px = 24'h200000 + 24'(i);
         push_pixel(px, 8'd0, 1'b0);
      end
      n_cmp++;
      if (level !== 4'd8 || full !== 1'b1) begin
         n_err++;
         $display("FAIL simul_full: got level=%0d full=%b want 8 1", level, full);
      end
      write_byte(8'h20);
      write_byte(8'h00);
      ready = 1'b1;
      write_byte(8'h09);
      n_cmp++;
      if (level !== 4'd7 || overflow !== 1'b1 || data_out !== 24'h200001) begin
         n_err++;
         $display("FAIL simul_level8: got level=%0d ovf=%b d=%h want 7 1 200001",
                  level, overflow, data_out);
      end
      for (int i = 2; i <= 8; i++) begin
         tick();
         px = 24'h200000 + 24'(i);
         n_cmp++;
         if (valid !== 1'b1 || data_out !== px) begin
            n_err++;
            $display("FAIL simul_order8[%0d]: got v=%b d=%h want v=1 d=%h", i, valid, data_out, px);
         end
      end
      tick();
      ready = 1'b0;
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL simul_dropped: got valid=%b d=%h want valid=0", valid, data_out);
      end
   endtask

   task automatic test_flush();
      // overflow is still set from the previous scenario.
      ready = 1'b0;
      rpt_in   = 8'd0;
      latch_in = 1'b0;
      write_byte(8'hAA);
      write_byte(8'hBB);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0 || idle !== 1'b1) begin
         n_err++;
         $display("FAIL flush_clear: got ovf=%b idle=%b want 0 1", overflow, idle);
      end
      push_pixel(24'h010203, 8'd0, 1'b0);
      tick();
      n_cmp++;
      if (valid !== 1'b1 || data_out !== 24'h010203) begin
         n_err++;
         $display("FAIL flush_pixel: got v=%b d=%h want v=1 d=010203", valid, data_out);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_cmp++;
      if (valid !== 1'b0 || idle !== 1'b1 || level !== 4'd0) begin
         n_err++;
         $display("FAIL flush_single: got v=%b idle=%b level=%0d want 0 1 0", valid, idle, level);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] px;
      ready = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         px = 24'h300000 + 24'(i);
         push_pixel(px, 8'd2, 1'b1);
      end
      n_cmp++;
      if (valid !== 1'b1 || level !== 4'd4) begin
         n_err++;
         $display("FAIL rstmid_setup: got v=%b level=%0d want 1 4", valid, level);
      end
      write_byte(8'hEE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({valid, latch, full, idle, overflow} !== 5'b00010 || data_out !== 24'h0
          || level !== 4'd0) begin
         n_err++;
         $display("FAIL rstmid_state: got flags=%b d=%h level=%0d want 00010 000000 0",
                  {valid, latch, full, idle, overflow}, data_out, level);
      end
      repeat (3) tick();
      n_cmp++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_quiet: valid got %b want 0", valid);
      end
      push_pixel(24'hC1C2C3, 8'd0, 1'b0);
      tick();
      n_cmp++;
      if (valid !== 1'b1 || data_out !== 24'hC1C2C3) begin
         n_err++;
         $display("FAIL rstmid_partial: got v=%b d=%h want v=1 d=c1c2c3", valid, data_out);
      end
   endtask

   initial begin
      rst      = 1'b1;
      byte_in  = 8'h00;
      byte_we  = 1'b0;
      rpt_in   = 8'h00;
      latch_in = 1'b0;
      flush    = 1'b0;
      ready    = 1'b0;
      test_reset();
      test_single();
      test_repeat();
      test_overflow();
      test_simultaneous();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
